regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 106 ++++++++++
 tb/tb_regfile_scoreboard.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Multi-port register file with write-through bypass and a
//            per-register pending-producer (busy) scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard #(
    parameter int                DATAW    = 32,
    parameter int                NUM_REGS = 32,
    parameter int                ADDRW    = $clog2(NUM_REGS),
    parameter int                NUM_RD   = 2,
    parameter logic [DATAW-1:0]  SP_RESET = 32'h01000000
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rd_en,
    input  logic [NUM_RD*ADDRW-1:0]   rd_addr,
    output logic [NUM_RD*DATAW-1:0]   rd_data,
    input  logic                      wr_en,
    input  logic [ADDRW-1:0]          wr_addr,
    input  logic [DATAW-1:0]          wr_data,
    input  logic                      issue_en,
    input  logic [ADDRW-1:0]          issue_addr,
    input  logic                      flush,
    output logic [NUM_RD-1:0]         rd_busy
);

    logic [DATAW-1:0]        regs_q [NUM_REGS];
    logic [DATAW-1:0]        regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]     busy_q;
    logic [NUM_REGS-1:0]     busy_d;
    logic [NUM_RD*DATAW-1:0] rd_data_q;
    logic [NUM_RD*DATAW-1:0] rd_data_d;
    logic                    wr_commit;

    assign wr_commit = wr_en && (wr_addr != '0);

    always_comb begin : write_path
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_commit) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    // Priority: write clears, a new issue sets over it, flush clears everything.
    always_comb begin : busy_path
        busy_d = busy_q;
        if (wr_commit) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_en && (issue_addr != '0)) begin
            busy_d[issue_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin : read_path
        logic [ADDRW-1:0] addr;
        logic             hit;
        addr      = '0;
        hit       = 1'b0;
        rd_data_d = rd_data_q;
        rd_busy   = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr       = rd_addr[k*ADDRW +: ADDRW];
            hit        = wr_commit && (wr_addr == addr);
            rd_busy[k] = (addr != '0) && busy_q[addr] && !hit;
            if (rd_en) begin
                if (addr == '0) begin
                    rd_data_d[k*DATAW +: DATAW] = '0;
                end else if (hit) begin
                    rd_data_d[k*DATAW +: DATAW] = wr_data;
                end else begin
                    rd_data_d[k*DATAW +: DATAW] = regs_q[addr];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 2) ? SP_RESET : '0;
            end
            busy_q    <= '0;
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Vector table, random traffic against a reference model, and
//            asynchronous-reset corner sequence for regfile_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_regfile_scoreboard;

    localparam int DATAW    = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDRW    = 5;
    localparam int NUM_RD   = 2;
    localparam logic [DATAW-1:0] SP = 32'h01000000;

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     rd_en = 1'b0;
    logic [NUM_RD*ADDRW-1:0]  rd_addr = '0;
    logic [NUM_RD*DATAW-1:0]  rd_data;
    logic                     wr_en = 1'b0;
    logic [ADDRW-1:0]         wr_addr = '0;
    logic [DATAW-1:0]         wr_data = '0;
    logic                     issue_en = 1'b0;
    logic [ADDRW-1:0]         issue_addr = '0;
    logic                     flush = 1'b0;
    logic [NUM_RD-1:0]        rd_busy;

    regfile_scoreboard #(
        .DATAW    (DATAW),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .SP_RESET (SP)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .rd_busy    (rd_busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural state as plain arrays.
    logic [DATAW-1:0]        m_regs [NUM_REGS];
    bit                      m_busy [NUM_REGS];
    logic [NUM_RD*DATAW-1:0] m_rd;

    typedef struct {
        bit               rd_en;
        int               a0;
        int               a1;
        bit               wr_en;
        int               wa;
        logic [DATAW-1:0] wd;
        bit               iss;
        int               ia;
        bit               fl;
        logic [1:0]       exp_busy;
        logic [DATAW-1:0] exp_rd0;
        logic [DATAW-1:0] exp_rd1;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
        m_regs[2] = SP;
        m_rd      = '0;
    endtask

    function automatic logic [NUM_RD-1:0] model_busy();
        logic [NUM_RD-1:0] r;
        int a;
        r = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a = int'(rd_addr[k*ADDRW +: ADDRW]);
            r[k] = (a != 0) && m_busy[a] && !(wr_en && int'(wr_addr) == a);
        end
        return r;
    endfunction

    task automatic model_edge();
        int a;
        if (rd_en) begin
            for (int k = 0; k < NUM_RD; k++) begin
                a = int'(rd_addr[k*ADDRW +: ADDRW]);
                if (a == 0)                                m_rd[k*DATAW +: DATAW] = '0;
                else if (wr_en && int'(wr_addr) == a)      m_rd[k*DATAW +: DATAW] = wr_data;
                else                                       m_rd[k*DATAW +: DATAW] = m_regs[a];
            end
        end
        if (wr_en && wr_addr != 0) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 0;
        end
        if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1;
        if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 0;
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string tag);
        check({tag, " rd_busy"}, 64'(rd_busy), 64'(model_busy()));
        @(posedge clock);
        model_edge();
        #1;
        check({tag, " rd_data"}, 64'(rd_data), 64'(m_rd));
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        rd_en = 0; wr_en = 0; issue_en = 0; flush = 0;
    endtask

    initial begin
        //            rd a0 a1  wr wa wd            is ia fl  busy   rd0           rd1
        vecs[0]  = '{1, 0, 2,  0, 0, 32'h0,        0, 0, 0,  2'b00, 32'h0,        SP};
        vecs[1]  = '{1, 5, 2,  1, 5, 32'hDEADBEEF, 0, 0, 0,  2'b00, 32'hDEADBEEF, SP};
        vecs[2]  = '{1, 0, 5,  1, 0, 32'hFFFFFFFF, 1, 0, 0,  2'b00, 32'h0,        32'hDEADBEEF};
        vecs[3]  = '{1, 0, 0,  0, 0, 32'h0,        0, 0, 0,  2'b00, 32'h0,        32'h0};
        vecs[4]  = '{0, 0, 0,  0, 0, 32'h0,        1, 7, 0,  2'b00, 32'h0,        32'h0};
        vecs[5]  = '{1, 7, 7,  0, 0, 32'h0,        0, 0, 0,  2'b11, 32'h0,        32'h0};
        vecs[6]  = '{1, 7, 5,  1, 7, 32'h77,       1, 7, 0,  2'b00, 32'h77,       32'hDEADBEEF};
        vecs[7]  = '{1, 7, 7,  0, 0, 32'h0,        0, 0, 0,  2'b11, 32'h77,       32'h77};
        vecs[8]  = '{1, 7, 7,  1, 7, 32'h88,       0, 0, 0,  2'b00, 32'h88,       32'h88};
        vecs[9]  = '{1, 7, 7,  0, 0, 32'h0,        0, 0, 0,  2'b00, 32'h88,       32'h88};
        vecs[10] = '{0, 3, 4,  0, 0, 32'h0,        1, 3, 0,  2'b00, 32'h88,       32'h88};
        vecs[11] = '{0, 3, 4,  0, 0, 32'h0,        1, 4, 0,  2'b01, 32'h88,       32'h88};
        vecs[12] = '{0, 4, 3,  0, 0, 32'h0,        1, 9, 0,  2'b11, 32'h88,       32'h88};
        vecs[13] = '{0, 9, 10, 0, 0, 32'h0,        1, 10, 1, 2'b01, 32'h88,       32'h88};
        vecs[14] = '{0, 9, 10, 0, 0, 32'h0,        0, 0, 0,  2'b00, 32'h88,       32'h88};
        vecs[15] = '{0, 3, 4,  0, 0, 32'h0,        0, 0, 0,  2'b00, 32'h88,       32'h88};

        model_reset();
        repeat (2) @(negedge clock);
        check("reset rd_data", 64'(rd_data), 64'h0);
        check("reset rd_busy", 64'(rd_busy), 64'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            rd_en      = vecs[i].rd_en;
            rd_addr    = {ADDRW'(vecs[i].a1), ADDRW'(vecs[i].a0)};
            wr_en      = vecs[i].wr_en;
            wr_addr    = ADDRW'(vecs[i].wa);
            wr_data    = vecs[i].wd;
            issue_en   = vecs[i].iss;
            issue_addr = ADDRW'(vecs[i].ia);
            flush      = vecs[i].fl;
            #1;
            check($sformatf("vec%0d busy", i), 64'(rd_busy), 64'(vecs[i].exp_busy));
            step($sformatf("vec%0d model", i));
            check($sformatf("vec%0d rd_data", i), 64'(rd_data), {vecs[i].exp_rd1, vecs[i].exp_rd0});
        end
        idle_inputs();

        // Random traffic on a narrow address window to force collisions.
        for (int c = 0; c < 300; c++) begin
            rd_en      = ($urandom_range(0, 9) < 7);
            rd_addr    = {ADDRW'($urandom_range(0, 15)), ADDRW'($urandom_range(0, 15))};
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = ADDRW'($urandom_range(0, 15));
            wr_data    = $urandom;
            issue_en   = ($urandom_range(0, 9) < 4);
            issue_addr = ADDRW'($urandom_range(0, 15));
            flush      = ($urandom_range(0, 19) == 0);
            #1;
            step($sformatf("rand%0d", c));
        end
        idle_inputs();

        // Asynchronous reset in the middle of a cycle.
        rd_en = 1; rd_addr = {ADDRW'(6), ADDRW'(6)};
        wr_en = 1; wr_addr = 6; wr_data = 32'h12345678;
        issue_en = 1; issue_addr = 6;
        #1;
        step("pre-reset write");
        idle_inputs();
        #1;
        check("pre-reset busy", 64'(rd_busy), 64'h3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset rd_data", 64'(rd_data), 64'h0);
        check("async reset rd_busy", 64'(rd_busy), 64'h0);
        model_reset();
        // A write presented while reset is held must be lost.
        wr_en = 1; wr_addr = 6; wr_data = 32'hCAFEF00D; issue_en = 1; issue_addr = 6;
        @(posedge clock);
        #1;
        check("held reset rd_data", 64'(rd_data), 64'h0);
        @(negedge clock);
        idle_inputs();
        reset_n = 1'b1;
        rd_en = 1; rd_addr = {ADDRW'(2), ADDRW'(6)};
        #1;
        check("post-reset busy", 64'(rd_busy), 64'h0);
        step("post-reset read");
        check("post-reset reg6/sp", 64'(rd_data), {SP, 32'h0});
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
